// File: rtl/fds_audio_loader_if.sv
// Bus bundle between the image loader, CPU bus, image RAM and the FDS audio unit port.
// The loader uses the slave modport; the side driving CPU/RAM/start stimulus uses master.
interface fds_audio_loader_if;
    logic        m2;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        start;
    logic [6:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic        aud_wr;
    logic [15:0] aud_addr;
    logic [7:0]  aud_din;
    logic        busy;
    logic        done;

    modport slave (
        input  m2, cpu_wr, cpu_rd, cpu_addr, cpu_din, start, mem_rdata,
        output mem_addr, aud_wr, aud_addr, aud_din, busy, done
    );

    modport master (
        output m2, cpu_wr, cpu_rd, cpu_addr, cpu_din, start, mem_rdata,
        input  mem_addr, aud_wr, aud_addr, aud_din, busy, done
    );
endinterface

// File: rtl/fds_audio_loader.sv
// Replays a 128-byte image into the FDS audio unit as 107 scripted writes, one per free M2 slot.
// Three clk per fetched step (FETCH, LOAD, HOLD); any CPU access at a slot wins and the step retries.
module fds_audio_loader #(
    parameter logic [6:0] WAVE_BASE = 7'h00,
    parameter logic [6:0] MOD_BASE  = 7'h40,
    parameter logic [6:0] REG_BASE  = 7'h60
) (
    input  logic                 clk,
    input  logic                 reset,
    fds_audio_loader_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, HOLD, FINISH} state_t;

    localparam logic [6:0] LAST_STEP = 7'd106;

    state_t     state_q, state_d;
    logic [6:0] step_q, step_d;
    logic [7:0] seq_data_q, seq_data_d;
    logic       pending_q, pending_d;
    logic [6:0] mem_addr_q, mem_addr_d;
    logic       old_m2_q;
    logic       slot, grant, advance;
    logic [6:0] nxt_step;
    logic [15:0] seq_addr;

    // Register offset x for the trailing $408x writes (steps 99..106).
    function automatic logic [3:0] reg_x(input logic [6:0] s);
        case (s)
            7'd99:   reg_x = 4'h0;
            7'd100:  reg_x = 4'h2;
            7'd101:  reg_x = 4'h3;
            7'd102:  reg_x = 4'h4;
            7'd103:  reg_x = 4'h5;
            7'd104:  reg_x = 4'h6;
            7'd105:  reg_x = 4'h7;
            default: reg_x = 4'hA;
        endcase
    endfunction

    function automatic logic is_const(input logic [6:0] s);
        is_const = (s == 7'd0) || (s == 7'd65);
    endfunction

    function automatic logic [6:0] img_addr(input logic [6:0] s);
        logic [6:0] wi;
        logic [6:0] mi;
        wi = s - 7'd1;
        mi = s - 7'd66;
        if (s <= 7'd64)      img_addr = WAVE_BASE + {1'b0, wi[5:0]};
        else if (s <= 7'd97) img_addr = MOD_BASE + {2'b0, mi[4:0]};
        else if (s == 7'd98) img_addr = REG_BASE + 7'd9;
        else                 img_addr = REG_BASE + {3'b0, reg_x(s)};
    endfunction

    always_comb begin
        logic [6:0] wi;
        wi = step_q - 7'd1;
        if (step_q == 7'd0)       seq_addr = 16'h4089;
        else if (step_q <= 7'd64) seq_addr = 16'h4040 + {10'b0, wi[5:0]};
        else if (step_q == 7'd65) seq_addr = 16'h4087;
        else if (step_q <= 7'd97) seq_addr = 16'h4088;
        else if (step_q == 7'd98) seq_addr = 16'h4089;
        else                      seq_addr = 16'h4080 + {12'b0, reg_x(step_q)};
    end

    assign slot  = ~old_m2_q & bus.m2;
    assign grant = slot & pending_q & ~bus.cpu_wr & ~bus.cpu_rd & (state_q == HOLD);

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        seq_data_d = seq_data_q;
        pending_d  = pending_q;
        mem_addr_d = mem_addr_q;
        advance    = 1'b0;
        nxt_step   = step_q + 7'd1;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    advance  = 1'b1;
                    nxt_step = 7'd0;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                seq_data_d = (step_q == 7'd98) ? {6'b0, bus.mem_rdata[1:0]} : bus.mem_rdata;
                pending_d  = 1'b1;
                state_d    = HOLD;
            end
            HOLD: begin
                if (grant) begin
                    pending_d = 1'b0;
                    if (step_q == LAST_STEP) state_d = FINISH;
                    else                     advance = 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Constant steps are ready immediately; the rest go through the RAM read.
        if (advance) begin
            step_d = nxt_step;
            if (is_const(nxt_step)) begin
                seq_data_d = 8'h80;
                pending_d  = 1'b1;
                state_d    = HOLD;
            end else begin
                mem_addr_d = img_addr(nxt_step);
                state_d    = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            step_q     <= 7'd0;
            seq_data_q <= 8'h00;
            pending_q  <= 1'b0;
            mem_addr_q <= 7'd0;
            old_m2_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            seq_data_q <= seq_data_d;
            pending_q  <= pending_d;
            mem_addr_q <= mem_addr_d;
            old_m2_q   <= bus.m2;
        end
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.aud_wr   = grant ? 1'b1     : bus.cpu_wr;
    assign bus.aud_addr = grant ? seq_addr : bus.cpu_addr;
    assign bus.aud_din  = grant ? seq_data_q : bus.cpu_din;
    assign bus.busy     = (state_q == FETCH) || (state_q == LOAD) || (state_q == HOLD);
    assign bus.done     = (state_q == FINISH);
endmodule

// File: tb/tb_fds_audio_loader.sv
// Directed bench for fds_audio_loader: ramp image, 5-clk M2 slots, write log checked against the script.
module tb_fds_audio_loader;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fds_audio_loader_if bus ();
    fds_audio_loader dut (.clk(clk), .reset(reset), .bus(bus));

    logic [7:0] img [128];
    always @(posedge clk) bus.mem_rdata <= img[bus.mem_addr];

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int base;
    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    logic [15:0] wq_addr [$];
    logic [7:0]  wq_dat [$];
    logic        s_wr, s_done, s_busy;
    logic [15:0] s_addr;
    logic [7:0]  s_din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] reg_x(input int s);
        case (s)
            99:      reg_x = 16'h0;
            100:     reg_x = 16'h2;
            101:     reg_x = 16'h3;
            102:     reg_x = 16'h4;
            103:     reg_x = 16'h5;
            104:     reg_x = 16'h6;
            105:     reg_x = 16'h7;
            default: reg_x = 16'hA;
        endcase
    endfunction

    // Expected script for a ramp image (img[k] = k).
    function automatic logic [15:0] exp_addr(input int s);
        if (s == 0)       exp_addr = 16'h4089;
        else if (s <= 64) exp_addr = 16'h4040 + 16'(s - 1);
        else if (s == 65) exp_addr = 16'h4087;
        else if (s <= 97) exp_addr = 16'h4088;
        else if (s == 98) exp_addr = 16'h4089;
        else              exp_addr = 16'h4080 + reg_x(s);
    endfunction

    function automatic logic [7:0] exp_dat(input int s);
        logic [15:0] x;
        x = reg_x(s);
        if (s == 0)       exp_dat = 8'h80;
        else if (s <= 64) exp_dat = 8'(s - 1);
        else if (s == 65) exp_dat = 8'h80;
        else if (s <= 97) exp_dat = 8'h40 + 8'(s - 66);
        else if (s == 98) exp_dat = 8'h01;
        else              exp_dat = 8'h60 + x[7:0];
    endfunction

    task automatic slot(input logic wr, input logic rd, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.m2 = 1'b1; bus.cpu_wr = wr; bus.cpu_rd = rd; bus.cpu_addr = a; bus.cpu_din = d;
        #1;
        s_wr = bus.aud_wr; s_addr = bus.aud_addr; s_din = bus.aud_din;
        if (bus.aud_wr === 1'b1) begin
            wq_addr.push_back(bus.aud_addr);
            wq_dat.push_back(bus.aud_din);
        end
        @(negedge clk);
        bus.m2 = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
        s_done = bus.done; s_busy = bus.busy;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic clear_log();
        wq_addr.delete();
        wq_dat.delete();
        s_done = 1'b0;
    endtask

    task automatic run_until_count(input int n, input string tag);
        int k = 0;
        while (wq_addr.size() < n && k < 200) begin
            slot(1'b0, 1'b0, 16'h0000, 8'h00);
            k++;
        end
        chk(tag, 32'(wq_addr.size()), 32'(n));
    endtask

    task automatic run_until_done(input string tag);
        int k = 0;
        s_done = 1'b0;
        while (!s_done && k < 200) begin
            slot(1'b0, 1'b0, 16'h0000, 8'h00);
            k++;
        end
        chk(tag, 32'(s_done), 32'd1);
    endtask

    task automatic check_script();
        for (int i = 0; i < 107 && i < wq_addr.size(); i++) begin
            chk($sformatf("script_addr[%0d]", i), 32'(wq_addr[i]), 32'(exp_addr(i)));
            chk($sformatf("script_dat[%0d]", i), 32'(wq_dat[i]), 32'(exp_dat(i)));
        end
    endtask

    initial begin
        for (int k = 0; k < 128; k++) img[k] = 8'(k);
        reset = 1'b1;
        bus.m2 = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
        bus.cpu_addr = 16'h1234; bus.cpu_din = 8'h00; bus.start = 1'b0;
        s_wr = 1'b0; s_done = 1'b0; s_busy = 1'b0; s_addr = 16'h0; s_din = 8'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state and passthrough
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_aud_wr", 32'(bus.aud_wr), 32'd0);
        chk("rst_aud_addr", 32'(bus.aud_addr), 32'h1234);

        // Idle CPU write passthrough
        slot(1'b1, 1'b0, 16'h4085, 8'h3F);
        chk("idle_wr", 32'(s_wr), 32'd1);
        chk("idle_addr", 32'(s_addr), 32'h4085);
        chk("idle_din", 32'(s_din), 32'h3F);
        chk("idle_busy", 32'(s_busy), 32'd0);

        // Full load without CPU traffic
        clear_log();
        base = done_cnt;
        pulse_start();
        chk("load_busy_after_start", 32'(bus.busy), 32'd1);
        run_until_done("load_done_seen");
        chk("load_last_slot_wr", 32'(s_wr), 32'd1);
        chk("load_last_slot_addr", 32'(s_addr), 32'h408A);
        chk("load_last_slot_din", 32'(s_din), 32'h6A);
        chk("load_busy_at_done", 32'(s_busy), 32'd0);
        chk("load_write_count", 32'(wq_addr.size()), 32'd107);
        check_script();
        @(negedge clk);
        chk("load_done_pulse_len", 32'(bus.done), 32'd0);
        chk("load_busy_after", 32'(bus.busy), 32'd0);
        chk("load_done_count", 32'(done_cnt - base), 32'd1);
        slot(1'b0, 1'b0, 16'h0000, 8'h00);
        slot(1'b0, 1'b0, 16'h0000, 8'h00);
        chk("load_no_extra_writes", 32'(wq_addr.size()), 32'd107);

        // CPU write wins the slot of s10, then CPU read stalls s20
        clear_log();
        base = done_cnt;
        pulse_start();
        run_until_count(10, "cont_reach_s10");
        slot(1'b1, 1'b0, 16'h4082, 8'h55);
        chk("cont_cpu_wr", 32'(s_wr), 32'd1);
        chk("cont_cpu_addr", 32'(s_addr), 32'h4082);
        chk("cont_cpu_din", 32'(s_din), 32'h55);
        slot(1'b0, 1'b0, 16'h0000, 8'h00);
        chk("cont_retry_addr", 32'(s_addr), 32'h4049);
        chk("cont_retry_din", 32'(s_din), 32'h09);
        run_until_count(21, "cont_reach_s20");
        slot(1'b0, 1'b1, 16'h4092, 8'h00);
        chk("rd_aud_wr", 32'(s_wr), 32'd0);
        chk("rd_aud_addr", 32'(s_addr), 32'h4092);
        chk("rd_step_held", 32'(wq_addr.size()), 32'd21);
        slot(1'b0, 1'b0, 16'h0000, 8'h00);
        chk("rd_retry_addr", 32'(s_addr), 32'h4053);
        chk("rd_retry_din", 32'(s_din), 32'h13);
        run_until_done("cont_done_seen");
        chk("cont_write_count", 32'(wq_addr.size()), 32'd108);
        @(negedge clk);
        chk("cont_done_count", 32'(done_cnt - base), 32'd1);

        // Reset mid-load at step 50
        clear_log();
        pulse_start();
        run_until_count(50, "rst_reach_s50");
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
        base = done_cnt;
        repeat (3) slot(1'b0, 1'b0, 16'h0000, 8'h00);
        chk("midrst_no_writes", 32'(wq_addr.size()), 32'd50);
        chk("midrst_no_done", 32'(done_cnt - base), 32'd0);

        // Reload from s0, with a start pulse ignored at step 20
        clear_log();
        pulse_start();
        run_until_count(20, "restart_reach_s20");
        pulse_start();
        chk("restart_busy_held", 32'(bus.busy), 32'd1);
        run_until_done("restart_done_seen");
        chk("restart_write_count", 32'(wq_addr.size()), 32'd107);
        check_script();
        @(negedge clk);
        chk("restart_done_count", 32'(done_cnt - base), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
